// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, NOP encoding
// and the default buffer depth.
package fetch_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  localparam int unsigned FETCH_DEPTH_DEFAULT = 2;
  localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two circular buffer with occupancy count, used both for the
// decoded-instruction buffer and for the in-flight request address tracker.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s;
  logic             do_pop_s;

  // A push into a full buffer is only taken when a pop frees a slot the same cycle.
  assign do_pop_s  = pop_i & (count_q != CNT_W'(0));
  assign do_push_s = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop_s);

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else if (clr_i) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_q <= do_pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_q  <= count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s && !clr_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order memory requests, buffers responses
// with their PC, and supports flush. Optional macro FETCH_ALIGN_CHECK_EN turns
// misaligned fetches into locally generated NOP entries flagged instr_misalign.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = FETCH_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              instr_misalign
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam int unsigned ENTRY_W = 33 + ADDR_W;
`else
  localparam int unsigned ENTRY_W = 32 + ADDR_W;
`endif

  fetch_state_e       state_q;
  logic [CNT_W-1:0]   buf_count_s;
  logic [CNT_W-1:0]   outstanding_s;
  logic [CNT_W-1:0]   outstanding_d;
  logic [SUM_W-1:0]   inflight_sum_s;
  logic [ADDR_W-1:0]  addr_head_s;
  logic [ENTRY_W-1:0] buf_wdata_s;
  logic [ENTRY_W-1:0] buf_rdata_s;
  logic               req_int_s;
  logic               grant_s;
  logic               rsp_ok_s;
  logic               rsp_push_s;
  logic               buf_push_s;
  logic               buf_pop_s;

  // Gating with rst_n keeps the request low while reset is held yet allows
  // a request in the very first cycle after release.
  assign inflight_sum_s = {1'b0, buf_count_s} + {1'b0, outstanding_s};
  assign req_int_s      = rst_n & (state_q == ST_RUN) & ~flush &
                          (inflight_sum_s < SUM_W'(DEPTH));
  assign imem_addr      = pc;
  assign grant_s        = imem_req & imem_gnt;

  assign rsp_ok_s      = imem_rvalid & (outstanding_s != CNT_W'(0));
  assign rsp_push_s    = rsp_ok_s & (state_q == ST_RUN) & ~flush;
  assign outstanding_d = outstanding_s + CNT_W'(grant_s) - CNT_W'(rsp_ok_s);

  assign instr_valid = (buf_count_s != CNT_W'(0));
  assign buf_pop_s   = instr_valid & instr_ready;
  assign instr       = instr_valid ? buf_rdata_s[ADDR_W +: 32] : 32'h0000_0000;
  assign instr_pc    = instr_valid ? buf_rdata_s[ADDR_W-1:0] : {ADDR_W{1'b0}};

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_s;
  logic nop_take_s;

  // A misaligned fetch waits until earlier responses are in so ordering holds.
  assign misalign_s     = (pc[1:0] != 2'b00);
  assign nop_take_s     = req_int_s & misalign_s & (outstanding_s == CNT_W'(0));
  assign imem_req       = req_int_s & ~misalign_s;
  assign pc_advance     = grant_s | nop_take_s;
  assign buf_push_s     = rsp_push_s | nop_take_s;
  assign buf_wdata_s    = nop_take_s ? {1'b1, NOP_INSTR, pc} : {1'b0, imem_rdata, addr_head_s};
  assign instr_misalign = instr_valid & buf_rdata_s[ENTRY_W-1];
`else
  assign imem_req    = req_int_s;
  assign pc_advance  = grant_s;
  assign buf_push_s  = rsp_push_s;
  assign buf_wdata_s = {imem_rdata, addr_head_s};
`endif

  // FSM: DRAIN swallows responses of requests issued before a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   state_q <= (flush && (outstanding_d != CNT_W'(0))) ? ST_DRAIN : ST_RUN;
        ST_DRAIN: state_q <= (outstanding_d == CNT_W'(0)) ? ST_RUN : ST_DRAIN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  // Granted addresses; its occupancy is the outstanding-request count.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_addr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .push_i  (grant_s),
    .pop_i   (rsp_ok_s),
    .wdata_i (pc),
    .rdata_o (addr_head_s),
    .count_o (outstanding_s)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_instr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .push_i  (buf_push_s),
    .pop_i   (buf_pop_s),
    .wdata_i (buf_wdata_s),
    .rdata_o (buf_rdata_s),
    .count_o (buf_count_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a one-cycle-latency memory model feeds
// responses, expected instructions are queued and compared on each pop.
module tb_fetch_unit;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ADDR_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [15:0] instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        instr_misalign;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .instr_misalign (instr_misalign)
`endif
  );

  typedef struct packed {logic [15:0] addr; logic drop;} fl_t;
  typedef struct packed {logic [31:0] instr; logic [15:0] pc;} exp_t;

  fl_t         inflight_q[$];
  exp_t        sb_q[$];
  logic [15:0] grant_log[$];
  fl_t         cur;
  bit          model_rsp;
  bit          rsp_en;
  int          checks;
  int          failures;
  int          pops;
  logic        s_req, s_adv, s_valid;
  logic [15:0] s_addr, s_ipc;
  logic [31:0] s_instr;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  // One clock cycle: sample at negedge, update scoreboard/memory model, drive after posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_adv   = pc_advance;
    s_valid = instr_valid;
    s_instr = instr;
    s_ipc   = instr_pc;
`ifndef FETCH_ALIGN_CHECK_EN
    check_eq("pc_advance_vs_grant", 64'(pc_advance), 64'(imem_req & imem_gnt));
`endif
    if (instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_instr_valid", 64'(instr_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        pops++;
        check_eq("instr", 64'(instr), 64'(e.instr));
        check_eq("instr_pc", 64'(instr_pc), 64'(e.pc));
      end
    end
    if (flush) begin
      sb_q.delete();
      foreach (inflight_q[i]) inflight_q[i].drop = 1'b1;
    end
    if (model_rsp && !flush && !cur.drop) sb_q.push_back({mem_data(cur.addr), cur.addr});
    if (imem_req && imem_gnt) begin
      grant_log.push_back(imem_addr);
      inflight_q.push_back({imem_addr, 1'b0});
    end
    @(posedge clk);
    #1;
    if (s_adv) pc = pc + 16'd4;
    if (rsp_en && inflight_q.size() > 0) begin
      cur         = inflight_q.pop_front();
      model_rsp   = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(cur.addr);
    end else begin
      model_rsp   = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; pops = 0;
    pc = 16'h0; flush = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; rsp_en = 1'b1; model_rsp = 1'b0;
    cur = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_imem_req", 64'(imem_req), 64'd0);
    check_eq("rst_pc_advance", 64'(pc_advance), 64'd0);
    check_eq("rst_instr_valid", 64'(instr_valid), 64'd0);
    check_eq("rst_instr", 64'(instr), 64'd0);
    check_eq("rst_instr_pc", 64'(instr_pc), 64'd0);

    // Reset release: addresses 0,4,8 issued in order, first one immediately.
    rst_n = 1'b1;
    cycle();
    check_eq("first_req_after_reset", 64'(s_req), 64'd1);
    check_eq("first_adv_after_reset", 64'(s_adv), 64'd1);
    for (int i = 0; i < 8 && grant_log.size() < 3; i++) cycle();
    imem_gnt = 1'b0;
    check_eq("grant_count_run", 64'(grant_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (grant_log.size() > i) check_eq("grant_addr_run", 64'(grant_log[i]), 64'(4 * i));
    end
    repeat (4) cycle();
    check_eq("pops_after_run", 64'(pops), 64'd3);

    // Withheld grant: request and address held, no advance.
    repeat (3) begin
      cycle();
      check_eq("hold_req", 64'(s_req), 64'd1);
      check_eq("hold_addr", 64'(s_addr), 64'h000C);
      check_eq("hold_adv", 64'(s_adv), 64'd0);
    end
    imem_gnt = 1'b1;
    cycle();
    check_eq("late_grant_adv", 64'(s_adv), 64'd1);
    check_eq("late_grant_addr", 64'(s_addr), 64'h000C);
    imem_gnt = 1'b0;
    repeat (3) cycle();

    // Back-pressure: exactly DEPTH grants, output held, resume one cycle after ready.
    grant_log.delete();
    instr_ready = 1'b0;
    imem_gnt = 1'b1;
    repeat (6) cycle();
    check_eq("bp_grant_count", 64'(grant_log.size()), 64'(DEPTH));
    check_eq("bp_req_low", 64'(s_req), 64'd0);
    imem_gnt = 1'b0;
    repeat (3) begin
      cycle();
      check_eq("bp_valid", 64'(s_valid), 64'd1);
      check_eq("bp_instr_stable", 64'(s_instr), 64'(mem_data(16'h0010)));
      check_eq("bp_pc_stable", 64'(s_ipc), 64'h0010);
    end
    instr_ready = 1'b1;
    cycle();
    check_eq("pop_no_same_cycle_req", 64'(s_req), 64'd0);
    cycle();
    check_eq("req_resumes", 64'(s_req), 64'd1);
    repeat (3) cycle();

    // Flush with a full buffer empties it at the next edge.
    instr_ready = 1'b0;
    pc = 16'h0040;
    imem_gnt = 1'b1;
    repeat (4) cycle();
    imem_gnt = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    check_eq("valid_after_flush", 64'(s_valid), 64'd0);

    // Flush with two requests in flight: responses dropped, then new pc fetched.
    instr_ready = 1'b1;
    rsp_en = 1'b0;
    pc = 16'h0100;
    imem_gnt = 1'b1;
    repeat (2) cycle();
    imem_gnt = 1'b0;
    rsp_en = 1'b1;
    cycle();
    check_eq("full_inflight_no_req", 64'(s_req), 64'd0);
    flush = 1'b1;
    pc = 16'h0200;
    cycle();
    flush = 1'b0;
    cycle();
    check_eq("drain_no_req", 64'(s_req), 64'd0);
    check_eq("drain_no_valid", 64'(s_valid), 64'd0);
    imem_gnt = 1'b1;
    cycle();
    check_eq("post_drain_req", 64'(s_req), 64'd1);
    check_eq("post_drain_addr", 64'(s_addr), 64'h0200);
    imem_gnt = 1'b0;
    repeat (3) cycle();

    // Reset during an outstanding request.
    instr_ready = 1'b0;
    pc = 16'h0300;
    imem_gnt = 1'b1;
    cycle();
    rsp_en = 1'b0;
    cycle();
    imem_gnt = 1'b0;
    cycle();
    check_eq("pre_reset_valid", 64'(s_valid), 64'd1);
    imem_gnt = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_imem_req", 64'(imem_req), 64'd0);
    check_eq("midrst_pc_advance", 64'(pc_advance), 64'd0);
    check_eq("midrst_instr_valid", 64'(instr_valid), 64'd0);
    check_eq("midrst_instr", 64'(instr), 64'd0);
    check_eq("midrst_instr_pc", 64'(instr_pc), 64'd0);
    inflight_q.delete();
    sb_q.delete();
    model_rsp = 1'b0;
    imem_gnt = 1'b0;
    instr_ready = 1'b1;
    pc = 16'h0500;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cycle();
    check_eq("req_after_reset_release", 64'(s_req), 64'd1);
    cycle();
    check_eq("stray_rvalid_ignored", 64'(s_valid), 64'd0);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned pc turns into a local NOP entry.
    instr_ready = 1'b0;
    imem_gnt = 1'b1;
    pc = 16'h0006;
    cycle();
    check_eq("misalign_no_req", 64'(s_req), 64'd0);
    imem_gnt = 1'b0;
    pc = 16'h0600;
    sb_q.push_back({32'h0000_0013, 16'h0006});
    check_eq("misalign_flag", 64'(instr_misalign), 64'd1);
    check_eq("misalign_valid", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    cycle();
    check_eq("total_pops", 64'(pops), 64'd8);
`else
    check_eq("total_pops", 64'(pops), 64'd7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the instruction buffer entries and the maximum in-flight requests (power of two, 2..8).
REQ-002 Parameter ADDR_W, default 16, SHALL set the address width, which matches the program counter width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 pc  in  ADDR_W  SHALL be the current program counter value.
REQ-006 pc_advance  out  1  SHALL be a request-accepted strobe that enables the next-PC update.
REQ-007 flush  in  1  SHALL discard all buffered and in-flight fetches.
REQ-008 imem_req  out  1; imem_addr  out  ADDR_W; imem_gnt  in  1  SHALL form the memory request handshake.
REQ-009 imem_rvalid  in  1; imem_rdata  in  32  SHALL carry the memory response.
REQ-010 instr_valid  out  1; instr_ready  in  1; instr  out  32; instr_pc  out  ADDR_W  SHALL carry the decode-side output.

Function
REQ-011 imem_req SHALL be high iff state RUN, flush low, and (buffer count + outstanding) < DEPTH, with no combinational path from instr_ready.
REQ-012 imem_addr SHALL equal pc whenever imem_req is high.
REQ-013 pc_advance SHALL be imem_req & imem_gnt, combinationally, in the grant cycle.
REQ-014 Each grant SHALL increment outstanding, and each counted imem_rvalid SHALL decrement it; a grant and an rvalid in the same cycle SHALL leave it unchanged.
REQ-015 Responses SHALL arrive in order, no earlier than the cycle after their grant; each SHALL be written to the buffer with instr_pc equal to its granted address.
REQ-016 instr_valid SHALL be high iff the buffer is non-empty; a pop SHALL occur on instr_valid & instr_ready.
REQ-017 instr and instr_pc SHALL be held stable while instr_valid & !instr_ready.
REQ-018 A push and a pop in the same cycle SHALL leave the count unchanged; a pop SHALL NOT enable imem_req in the same cycle.
REQ-019 The FSM SHALL have two states: RUN and DRAIN.
REQ-020 On flush the buffer SHALL be emptied at the next edge (instr_valid low the following cycle); the FSM SHALL go to DRAIN if in-flight responses remain after that cycle, otherwise stay in RUN.
REQ-021 In DRAIN, imem_req SHALL be low and responses SHALL be counted but not written; the FSM SHALL return to RUN on the edge where outstanding reaches 0.
REQ-022 An rvalid coinciding with flush SHALL be discarded, and flush while in DRAIN SHALL have no additional effect.
REQ-023 imem_rvalid with outstanding = 0 SHALL be ignored.

Reset
REQ-024 While rst_n is low: imem_req=0, pc_advance=0, instr_valid=0, instr=0, instr_pc=0, outstanding=0, buffer empty, FSM in RUN.
REQ-025 Reset assertion mid-transaction SHALL abandon all in-flight requests, and the first imem_req SHALL be possible in the first cycle after deassertion.

Configuration
REQ-026 With FETCH_ALIGN_CHECK_EN defined, a grant with pc[1:0] != 0 SHALL instead push an entry with instr=32'h0000_0013 (NOP) and an extra output instr_misalign=1, without reaching memory and without incrementing outstanding.
REQ-027 Without FETCH_ALIGN_CHECK_EN, the port instr_misalign and the check SHALL be absent, and every address SHALL be issued unchanged.

Structure
REQ-028 Package fetch_pkg SHALL hold the FSM state enum, the NOP constant and the DEPTH default.
REQ-029 The buffer SHALL be sub-module fetch_fifo (parameterised DEPTH, width 32+ADDR_W, with count output).

Verification
REQ-030 Reset release, with imem_gnt=1, one-cycle latency and instr_ready=1 -> addresses 0,4,8 issued back-to-back; instr_pc 0,4,8 in order; pc_advance high each cycle.
REQ-031 instr_ready=0, DEPTH=2 -> exactly 2 grants, then imem_req low; instr held stable; raising instr_ready resumes requests one cycle later.
REQ-032 2 requests in flight, flush pulse -> instr_valid low the next cycle; both rvalids discarded; the next request addresses the new pc after outstanding=0.
REQ-033 rst_n low during an outstanding request -> all outputs 0 immediately; the late rvalid after reset is ignored.
REQ-034 imem_gnt withheld for 3 cycles -> imem_req/imem_addr held stable; pc_advance stays low until the grant.
REQ-035 (FETCH_ALIGN_CHECK_EN) pc=0x0006 -> no memory request; entry with instr=0x00000013, instr_misalign=1, instr_pc=0x0006.
